// File: rtl/bomb_manager.sv
`default_nettype none
// ============================================================================
//  Module      : bomb_manager
//  Description : Bomb slot pool for two players. It accepts bomb requests on
//                the rising edge of each player's request line and counts each
//                fuse in game ticks. It drains explosions one per cycle and
//                stuns any player caught in a cross-shaped blast.
//  Revision    : 1.0  initial release
// ============================================================================
module bomb_manager #(
  parameter int MAX_BOMBS    = 4,
  parameter int FUSE_TICKS   = 6,
  parameter int BLAST_RADIUS = 2,
  parameter int STUN_TICKS   = 8
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       tick,
  input  logic       p1_bomb_req,
  input  logic [5:0] p1_x,
  input  logic [5:0] p1_y,
  input  logic       p2_bomb_req,
  input  logic [5:0] p2_x,
  input  logic [5:0] p2_y,
  output logic       p1_ack,
  output logic       p1_nak,
  output logic       p2_ack,
  output logic       p2_nak,
  output logic       explode_valid,
  output logic [5:0] explode_x,
  output logic [5:0] explode_y,
  output logic       p1_stunned,
  output logic       p2_stunned,
  output logic [2:0] active_count
);

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_ARMED   = 2'd1,
    SLOT_EXPIRED = 2'd2
  } slot_state_e;

  localparam logic [5:0] C_FUSE   = 6'(FUSE_TICKS);
  localparam logic [5:0] C_STUN   = 6'(STUN_TICKS);
  localparam logic [5:0] C_RADIUS = 6'(BLAST_RADIUS);

  // Slot pool
  slot_state_e slot_state_q [MAX_BOMBS];
  slot_state_e slot_state_d [MAX_BOMBS];
  logic [5:0]  slot_x_q     [MAX_BOMBS];
  logic [5:0]  slot_x_d     [MAX_BOMBS];
  logic [5:0]  slot_y_q     [MAX_BOMBS];
  logic [5:0]  slot_y_d     [MAX_BOMBS];
  logic [5:0]  slot_fuse_q  [MAX_BOMBS];
  logic [5:0]  slot_fuse_d  [MAX_BOMBS];

  // Per-player request edge memory and stun counters
  logic       p1_prev_q, p1_prev_d;
  logic       p2_prev_q, p2_prev_d;
  logic [5:0] p1_stun_q, p1_stun_d;
  logic [5:0] p2_stun_q, p2_stun_d;

  // Registered outputs
  logic       p1_ack_q, p1_ack_d;
  logic       p1_nak_q, p1_nak_d;
  logic       p2_ack_q, p2_ack_d;
  logic       p2_nak_q, p2_nak_d;
  logic       explode_valid_q, explode_valid_d;
  logic [5:0] explode_x_q, explode_x_d;
  logic [5:0] explode_y_q, explode_y_d;
  logic [2:0] active_count_q, active_count_d;

  // Decision helpers
  logic                 p1_req, p2_req;
  logic                 p1_dup, p2_dup;
  logic                 same_cell;
  logic                 p1_taken, p2_taken;
  logic                 exp_taken;
  logic                 p1_hit, p2_hit;
  logic [MAX_BOMBS-1:0] p1_slot;

  // Cross-shaped reach test using unsigned distances (larger minus smaller)
  function automatic logic in_blast(input logic [5:0] px, input logic [5:0] py,
                                    input logic [5:0] ex, input logic [5:0] ey);
    logic [5:0] dx;
    logic [5:0] dy;
    dx = (px >= ex) ? (px - ex) : (ex - px);
    dy = (py >= ey) ? (py - ey) : (ey - py);
    return ((px == ex) && (dy <= C_RADIUS)) || ((py == ey) && (dx <= C_RADIUS));
  endfunction

  // Next state: fuse countdown, explosion drain, allocation, stun and reset
  always_comb begin
    slot_state_d    = slot_state_q;
    slot_x_d        = slot_x_q;
    slot_y_d        = slot_y_q;
    slot_fuse_d     = slot_fuse_q;
    p1_prev_d       = p1_bomb_req;
    p2_prev_d       = p2_bomb_req;
    p1_stun_d       = p1_stun_q;
    p2_stun_d       = p2_stun_q;
    p1_ack_d        = 1'b0;
    p1_nak_d        = 1'b0;
    p2_ack_d        = 1'b0;
    p2_nak_d        = 1'b0;
    explode_valid_d = 1'b0;
    explode_x_d     = 6'd0;
    explode_y_d     = 6'd0;
    active_count_d  = 3'd0;
    p1_dup          = 1'b0;
    p2_dup          = 1'b0;
    p1_taken        = 1'b0;
    p2_taken        = 1'b0;
    exp_taken       = 1'b0;
    p1_slot         = '0;

    // A request is a rising edge from a player who is not stunned
    p1_req    = p1_bomb_req & ~p1_prev_q & (p1_stun_q == 6'd0);
    p2_req    = p2_bomb_req & ~p2_prev_q & (p2_stun_q == 6'd0);
    same_cell = p1_req & (p1_x == p2_x) & (p1_y == p2_y);

    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (slot_state_q[i] != SLOT_FREE) begin
        if ((slot_x_q[i] == p1_x) && (slot_y_q[i] == p1_y)) p1_dup = 1'b1;
        if ((slot_x_q[i] == p2_x) && (slot_y_q[i] == p2_y)) p2_dup = 1'b1;
      end
    end

    // Fuse countdown; a slot armed this cycle is still FREE here, so it
    // cannot consume a tick that lands in its arm cycle.
    for (int i = 0; i < MAX_BOMBS; i++) begin
      if ((slot_state_q[i] == SLOT_ARMED) && tick) begin
        slot_fuse_d[i] = slot_fuse_q[i] - 6'd1;
        if (slot_fuse_q[i] == 6'd1) slot_state_d[i] = SLOT_EXPIRED;
      end
    end

    // Lowest-index expired slot reports and is released
    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (!exp_taken && (slot_state_q[i] == SLOT_EXPIRED)) begin
        exp_taken       = 1'b1;
        slot_state_d[i] = SLOT_FREE;
        explode_valid_d = 1'b1;
        explode_x_d     = slot_x_q[i];
        explode_y_d     = slot_y_q[i];
      end
    end

    // Player 1 takes the lowest free slot first
    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (p1_req && !p1_dup && !p1_taken && (slot_state_q[i] == SLOT_FREE)) begin
        p1_taken        = 1'b1;
        p1_slot[i]      = 1'b1;
        slot_state_d[i] = SLOT_ARMED;
        slot_x_d[i]     = p1_x;
        slot_y_d[i]     = p1_y;
        slot_fuse_d[i]  = C_FUSE;
      end
    end

    // Player 2 takes the next free slot not claimed by player 1
    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (p2_req && !p2_dup && !same_cell && !p2_taken && !p1_slot[i] &&
          (slot_state_q[i] == SLOT_FREE)) begin
        p2_taken        = 1'b1;
        slot_state_d[i] = SLOT_ARMED;
        slot_x_d[i]     = p2_x;
        slot_y_d[i]     = p2_y;
        slot_fuse_d[i]  = C_FUSE;
      end
    end

    p1_ack_d = p1_taken;
    p1_nak_d = p1_req & ~p1_taken;
    p2_ack_d = p2_taken;
    p2_nak_d = p2_req & ~p2_taken;

    // Stun counters: a hit reloads and beats a same-cycle tick
    p1_hit = explode_valid_q & in_blast(p1_x, p1_y, explode_x_q, explode_y_q);
    p2_hit = explode_valid_q & in_blast(p2_x, p2_y, explode_x_q, explode_y_q);
    if (p1_hit) p1_stun_d = C_STUN;
    else if (tick && (p1_stun_q != 6'd0)) p1_stun_d = p1_stun_q - 6'd1;
    if (p2_hit) p2_stun_d = C_STUN;
    else if (tick && (p2_stun_q != 6'd0)) p2_stun_d = p2_stun_q - 6'd1;

    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (slot_state_d[i] != SLOT_FREE) active_count_d = active_count_d + 3'd1;
    end

    // Synchronous reset discards every bomb without an explosion
    if (!Reset) begin
      for (int i = 0; i < MAX_BOMBS; i++) begin
        slot_state_d[i] = SLOT_FREE;
        slot_x_d[i]     = 6'd0;
        slot_y_d[i]     = 6'd0;
        slot_fuse_d[i]  = 6'd0;
      end
      p1_prev_d       = 1'b0;
      p2_prev_d       = 1'b0;
      p1_stun_d       = 6'd0;
      p2_stun_d       = 6'd0;
      p1_ack_d        = 1'b0;
      p1_nak_d        = 1'b0;
      p2_ack_d        = 1'b0;
      p2_nak_d        = 1'b0;
      explode_valid_d = 1'b0;
      explode_x_d     = 6'd0;
      explode_y_d     = 6'd0;
      active_count_d  = 3'd0;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    slot_state_q    <= slot_state_d;
    slot_x_q        <= slot_x_d;
    slot_y_q        <= slot_y_d;
    slot_fuse_q     <= slot_fuse_d;
    p1_prev_q       <= p1_prev_d;
    p2_prev_q       <= p2_prev_d;
    p1_stun_q       <= p1_stun_d;
    p2_stun_q       <= p2_stun_d;
    p1_ack_q        <= p1_ack_d;
    p1_nak_q        <= p1_nak_d;
    p2_ack_q        <= p2_ack_d;
    p2_nak_q        <= p2_nak_d;
    explode_valid_q <= explode_valid_d;
    explode_x_q     <= explode_x_d;
    explode_y_q     <= explode_y_d;
    active_count_q  <= active_count_d;
  end

  assign p1_ack        = p1_ack_q;
  assign p1_nak        = p1_nak_q;
  assign p2_ack        = p2_ack_q;
  assign p2_nak        = p2_nak_q;
  assign explode_valid = explode_valid_q;
  assign explode_x     = explode_x_q;
  assign explode_y     = explode_y_q;
  assign p1_stunned    = (p1_stun_q != 6'd0);
  assign p2_stunned    = (p2_stun_q != 6'd0);
  assign active_count  = active_count_q;

endmodule
`default_nettype wire

// File: tb/tb_bomb_manager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bomb_manager
//  Description : Directed bench for bomb_manager with a slot/tick level model
//                compared every cycle, plus hand-computed scenario checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bomb_manager;

  logic       clock = 1'b0;
  logic       Reset = 1'b0;
  logic       tick = 1'b0;
  logic       p1_bomb_req = 1'b0;
  logic [5:0] p1_x = 6'd0;
  logic [5:0] p1_y = 6'd0;
  logic       p2_bomb_req = 1'b0;
  logic [5:0] p2_x = 6'd15;
  logic [5:0] p2_y = 6'd15;
  logic       p1_ack, p1_nak, p2_ack, p2_nak;
  logic       explode_valid;
  logic [5:0] explode_x, explode_y;
  logic       p1_stunned, p2_stunned;
  logic [2:0] active_count;

  bomb_manager dut (
    .clock         (clock),
    .Reset         (Reset),
    .tick          (tick),
    .p1_bomb_req   (p1_bomb_req),
    .p1_x          (p1_x),
    .p1_y          (p1_y),
    .p2_bomb_req   (p2_bomb_req),
    .p2_x          (p2_x),
    .p2_y          (p2_y),
    .p1_ack        (p1_ack),
    .p1_nak        (p1_nak),
    .p2_ack        (p2_ack),
    .p2_nak        (p2_nak),
    .explode_valid (explode_valid),
    .explode_x     (explode_x),
    .explode_y     (explode_y),
    .p1_stunned    (p1_stunned),
    .p2_stunned    (p2_stunned),
    .active_count  (active_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each bomb is just "busy" plus ticks left; zero ticks left means expired.
  bit m_busy [4];
  int m_x    [4];
  int m_y    [4];
  int m_left [4];
  int m_s1, m_s2;
  bit m_pv1, m_pv2;
  bit e_ack1, e_nak1, e_ack2, e_nak2, e_ev;
  int e_ex, e_ey, e_cnt;
  bit model_ok = 1'b0;

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic bit caught(input int px, input int py, input int ex, input int ey);
    return ((px == ex) && (absdiff(py, ey) <= 2)) || ((py == ey) && (absdiff(px, ex) <= 2));
  endfunction

  always @(posedge clock) begin : model
    int xi, f1, f2, p2s, px1, py1, px2, py2;
    bit r1, r2, dup1, dup2, a1, a2, h1, h2, same;
    if (!Reset) begin
      for (int i = 0; i < 4; i++) begin
        m_busy[i] = 1'b0; m_left[i] = 0; m_x[i] = 0; m_y[i] = 0;
      end
      m_s1 = 0; m_s2 = 0; m_pv1 = 1'b0; m_pv2 = 1'b0;
      e_ack1 = 1'b0; e_nak1 = 1'b0; e_ack2 = 1'b0; e_nak2 = 1'b0;
      e_ev = 1'b0; e_ex = 0; e_ey = 0; e_cnt = 0;
      model_ok = 1'b1;
    end else begin
      px1 = int'(p1_x); py1 = int'(p1_y); px2 = int'(p2_x); py2 = int'(p2_y);
      h1 = e_ev && caught(px1, py1, e_ex, e_ey);
      h2 = e_ev && caught(px2, py2, e_ex, e_ey);
      r1 = p1_bomb_req && !m_pv1 && (m_s1 == 0);
      r2 = p2_bomb_req && !m_pv2 && (m_s2 == 0);
      m_pv1 = p1_bomb_req;
      m_pv2 = p2_bomb_req;
      xi = -1; f1 = -1; f2 = -1; dup1 = 1'b0; dup2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (m_busy[i] && (m_left[i] == 0) && (xi < 0)) xi = i;
        if (m_busy[i] && (m_x[i] == px1) && (m_y[i] == py1)) dup1 = 1'b1;
        if (m_busy[i] && (m_x[i] == px2) && (m_y[i] == py2)) dup2 = 1'b1;
        if (!m_busy[i]) begin
          if (f1 < 0) f1 = i;
          else if (f2 < 0) f2 = i;
        end
      end
      a1   = r1 && !dup1 && (f1 >= 0);
      same = r1 && (px1 == px2) && (py1 == py2);
      p2s  = a1 ? f2 : f1;
      a2   = r2 && !dup2 && !same && (p2s >= 0);
      e_ack1 = a1; e_nak1 = r1 && !a1;
      e_ack2 = a2; e_nak2 = r2 && !a2;
      if (tick)
        for (int i = 0; i < 4; i++)
          if (m_busy[i] && (m_left[i] > 0)) m_left[i]--;
      e_ev = 1'b0;
      if (xi >= 0) begin
        e_ev = 1'b1; e_ex = m_x[xi]; e_ey = m_y[xi]; m_busy[xi] = 1'b0;
      end
      if (a1) begin m_busy[f1] = 1'b1; m_x[f1] = px1; m_y[f1] = py1; m_left[f1] = 6; end
      if (a2) begin m_busy[p2s] = 1'b1; m_x[p2s] = px2; m_y[p2s] = py2; m_left[p2s] = 6; end
      m_s1 = h1 ? 8 : ((tick && (m_s1 > 0)) ? m_s1 - 1 : m_s1);
      m_s2 = h2 ? 8 : ((tick && (m_s2 > 0)) ? m_s2 - 1 : m_s2);
      e_cnt = 0;
      for (int i = 0; i < 4; i++) if (m_busy[i]) e_cnt++;
    end
  end

  // ---------------- per-cycle compare and event logging ----------------
  int n_ack1, n_nak1, n_ack2, n_nak2, n_expl, n_both, n_p1stun;
  int log_x[$];
  int log_y[$];
  int log_c[$];
  int cyc = 0;

  always @(posedge clock) cyc++;

  always @(posedge clock) begin
    #1;
    if (model_ok) begin
      check("p1_ack", 32'(p1_ack), 32'(e_ack1));
      check("p1_nak", 32'(p1_nak), 32'(e_nak1));
      check("p2_ack", 32'(p2_ack), 32'(e_ack2));
      check("p2_nak", 32'(p2_nak), 32'(e_nak2));
      check("explode_valid", 32'(explode_valid), 32'(e_ev));
      if (e_ev) begin
        check("explode_x", 32'(explode_x), e_ex);
        check("explode_y", 32'(explode_y), e_ey);
      end
      check("p1_stunned", 32'(p1_stunned), 32'(m_s1 != 0));
      check("p2_stunned", 32'(p2_stunned), 32'(m_s2 != 0));
      check("active_count", 32'(active_count), e_cnt);
      if (p1_ack) n_ack1++;
      if (p1_nak) n_nak1++;
      if (p2_ack) n_ack2++;
      if (p2_nak) n_nak2++;
      if (p1_ack && p2_nak) n_both++;
      if (p1_stunned) n_p1stun++;
      if (explode_valid) begin
        n_expl++;
        log_x.push_back(int'(explode_x));
        log_y.push_back(int'(explode_y));
        log_c.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers (entered and left at a negedge) -------
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    @(negedge clock);
  endtask

  task automatic ticks(input int n);
    repeat (n) pulse_tick();
  endtask

  task automatic p1_pulse(input int x, input int y);
    p1_x = 6'(x); p1_y = 6'(y); p1_bomb_req = 1'b1;
    @(negedge clock);
    p1_bomb_req = 1'b0;
    idle(2);
  endtask

  task automatic p2_pulse(input int x, input int y);
    p2_x = 6'(x); p2_y = 6'(y); p2_bomb_req = 1'b1;
    @(negedge clock);
    p2_bomb_req = 1'b0;
    idle(2);
  endtask

  task automatic clear_counts();
    n_ack1 = 0; n_nak1 = 0; n_ack2 = 0; n_nak2 = 0;
    n_expl = 0; n_both = 0; n_p1stun = 0;
    log_x.delete(); log_y.delete(); log_c.delete();
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    @(negedge clock);
    Reset = 1'b1;
    @(negedge clock);
    clear_counts();
  endtask

  function automatic int first_or(ref int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : -1;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    clear_counts();
    Reset = 1'b0;
    idle(2);
    check("reset_active_count", 32'(active_count), 0);
    check("reset_explode_valid", 32'(explode_valid), 0);
    check("reset_acks", 32'({p1_ack, p1_nak, p2_ack, p2_nak}), 0);
    check("reset_stunned", 32'({p1_stunned, p2_stunned}), 0);
    Reset = 1'b1;
    idle(1);
    clear_counts();

    // 1: held level gives one ack; bomb fires after six ticks
    p1_x = 6'd3; p1_y = 6'd4; p1_bomb_req = 1'b1;
    idle(20);
    p1_bomb_req = 1'b0;
    idle(2);
    check("s1_ack_count", n_ack1, 1);
    check("s1_nak_count", n_nak1, 0);
    check("s1_active", 32'(active_count), 1);
    p1_x = 6'd15; p1_y = 6'd0;
    ticks(5);
    idle(3);
    check("s1_no_early_explode", n_expl, 0);
    ticks(1);
    idle(3);
    check("s1_explode_count", n_expl, 1);
    check("s1_explode_x", first_or(log_x, 0), 3);
    check("s1_explode_y", first_or(log_y, 0), 4);
    check("s1_active_after", 32'(active_count), 0);

    // 2: pool full rejects, freed slot accepts again
    do_reset();
    p1_pulse(0, 0);
    ticks(3);
    p1_pulse(2, 0);
    p1_pulse(4, 0);
    p1_pulse(6, 0);
    p2_pulse(10, 10);
    check("s2_ack1_count", n_ack1, 4);
    check("s2_nak2_count", n_nak2, 1);
    check("s2_active_full", 32'(active_count), 4);
    p1_x = 6'd14; p1_y = 6'd14;
    ticks(3);
    idle(3);
    check("s2_explode_count", n_expl, 1);
    check("s2_explode_x", first_or(log_x, 0), 0);
    check("s2_active_after_expl", 32'(active_count), 3);
    p2_pulse(10, 10);
    check("s2_ack2_count", n_ack2, 1);
    check("s2_active_refill", 32'(active_count), 4);

    // 3: same-cycle edges at one cell with one slot left
    do_reset();
    p1_pulse(1, 0);
    p1_pulse(3, 0);
    p1_pulse(5, 0);
    p1_x = 6'd5; p1_y = 6'd5; p2_x = 6'd5; p2_y = 6'd5;
    p1_bomb_req = 1'b1; p2_bomb_req = 1'b1;
    @(negedge clock);
    p1_bomb_req = 1'b0; p2_bomb_req = 1'b0;
    idle(2);
    check("s3_same_cycle", n_both, 1);
    check("s3_ack1_count", n_ack1, 4);
    check("s3_ack2_count", n_ack2, 0);
    check("s3_active", 32'(active_count), 4);

    // 4: two bombs expiring together drain lowest slot first
    do_reset();
    p1_x = 6'd1; p1_y = 6'd1; p2_x = 6'd9; p2_y = 6'd9;
    p1_bomb_req = 1'b1; p2_bomb_req = 1'b1;
    @(negedge clock);
    p1_bomb_req = 1'b0; p2_bomb_req = 1'b0;
    idle(2);
    check("s4_acks", n_ack1 + n_ack2, 2);
    p1_x = 6'd15; p1_y = 6'd15; p2_x = 6'd15; p2_y = 6'd13;
    ticks(6);
    idle(4);
    check("s4_explode_count", n_expl, 2);
    check("s4_first_x", first_or(log_x, 0), 1);
    check("s4_first_y", first_or(log_y, 0), 1);
    check("s4_second_x", first_or(log_x, 1), 9);
    check("s4_second_y", first_or(log_y, 1), 9);
    check("s4_consecutive", first_or(log_c, 1) - first_or(log_c, 0), 1);

    // 5: blast stuns P2 for eight ticks, P1 just outside the cross
    do_reset();
    p1_pulse(7, 7);
    p1_x = 6'd9; p1_y = 6'd8; p2_x = 6'd7; p2_y = 6'd9;
    ticks(6);
    idle(2);
    check("s5_explode_count", n_expl, 1);
    check("s5_p2_stunned", 32'(p2_stunned), 1);
    check("s5_p1_never_stunned", n_p1stun, 0);
    n_ack2 = 0; n_nak2 = 0;
    p2_pulse(7, 9);
    p2_pulse(7, 9);
    check("s5_stunned_req_ack", n_ack2, 0);
    check("s5_stunned_req_nak", n_nak2, 0);
    check("s5_active", 32'(active_count), 0);
    ticks(7);
    check("s5_stun_after_7", 32'(p2_stunned), 1);
    ticks(1);
    check("s5_stun_after_8", 32'(p2_stunned), 0);

    // 6: mid-operation reset discards armed bombs and stun
    do_reset();
    p2_pulse(0, 12);
    p2_x = 6'd15; p2_y = 6'd15;
    ticks(3);
    p1_pulse(2, 2);
    p1_pulse(4, 2);
    p1_pulse(6, 2);
    p1_x = 6'd0; p1_y = 6'd13;
    ticks(3);
    idle(3);
    check("s6_p1_stunned", 32'(p1_stunned), 1);
    check("s6_active_before", 32'(active_count), 3);
    Reset = 1'b0;
    @(negedge clock);
    check("s6_active_reset", 32'(active_count), 0);
    check("s6_stun_reset", 32'(p1_stunned), 0);
    Reset = 1'b1;
    clear_counts();
    ticks(8);
    idle(3);
    check("s6_no_explode", n_expl, 0);
    check("s6_active_end", 32'(active_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
